dispatcher_multilane: RTL and testbench
=======================================

DISPATCHER_MULTILANE -- requirements
Module: dispatcher_multilane

Interface
REQ-001 SHALL have parameter NUM_LANES, 4, dispatch lanes (power of 2, 1..16).
REQ-002 SHALL have parameter MAX_THREADS, 1024, thread slots (power of 2).
REQ-003 SHALL have parameter FIFO_DEPTH, 8, entries per lane FIFO (power of 2, >=2).
REQ-004 SHALL have parameter NUM_REGS, 66, register bitmap width; TID_W = log2(MAX_THREADS) derived.
REQ-005 SHALL have port clk input 1 clock; one clock domain.
REQ-006 SHALL have port rst input 1 reset, synchronous, active-high.
REQ-007 SHALL have ports start input 1 (launch pulse), abort input 1 (flush request).
REQ-008 SHALL have ports unrolling_factor input 2 and thread_count input TID_W+1 (threads in CTA).
REQ-009 SHALL have ports active_mask input MAX_THREADS, input_register_bitmap input NUM_REGS, pending_reg_bitmap input NUM_REGS.
REQ-010 SHALL have ports wb_valid input 1, wb_tid_bitmap input MAX_THREADS, ld_dest_reg input 8.
REQ-011 SHALL have ports dispatch_pop input NUM_LANES, dispatch_tid output NUM_LANES*TID_W (lane l at [l*TID_W +: TID_W]), dispatch_valid output NUM_LANES.
REQ-012 SHALL have ports dispatcher_busy output 1, dispatcher_done output 1, dispatched_count output TID_W+1.

Function
REQ-013 SHALL implement FSM IDLE, SCAN, DRAIN, DONE; dispatcher_busy = (state != IDLE).
REQ-014 IDLE: start=1 SHALL latch active_mask, thread_count, L_eff = min(NUM_LANES, 1<<unrolling_factor), dep_regs = input_register_bitmap & pending_reg_bitmap; clear scan pointer and dispatched_count; go to SCAN next cycle.
REQ-015 At start, waiting[t] SHALL be set for every latched-active t iff dep_regs != 0, else cleared.
REQ-016 wb_valid=1 with ld_dest_reg < NUM_REGS and dep_regs[ld_dest_reg]=1 SHALL clear waiting[t] for every t set in wb_tid_bitmap, next cycle; otherwise ignored.
REQ-017 SCAN: current group = tids ptr..ptr+L_eff-1 clipped to thread_count; thread t qualifies iff active and not yet dispatched; t maps to lane t mod L_eff.
REQ-018 Group SHALL push atomically in one cycle only if no qualifying thread is waiting and every target lane FIFO has count < FIFO_DEPTH (evaluated on registered count; same-cycle pop does not free space); else stall.
REQ-019 After a push, or for a group with no qualifying threads, ptr SHALL advance by L_eff; ptr >= thread_count SHALL move to DRAIN.
REQ-020 dispatched_count SHALL increment by the number of threads pushed each cycle.
REQ-021 Lane FIFO SHALL be show-ahead: dispatch_valid[l] = not empty, dispatch_tid lane l = head; dispatch_pop[l] on empty lane ignored; push and pop same cycle legal.
REQ-022 Latency: start in cycle N -> SCAN in N+1 -> first dispatch_valid in N+2 when unblocked.
REQ-023 DRAIN: all lane FIFOs empty SHALL go to DONE; DONE SHALL assert dispatcher_done for exactly one cycle, then IDLE.
REQ-024 thread_count = 0 or empty active_mask SHALL pass SCAN->DRAIN->DONE with no pushes.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort in any state SHALL empty all FIFOs, clear waiting and ptr, go to IDLE next cycle without dispatcher_done; abort wins over simultaneous start, push, pop and wb.

Reset
REQ-027 rst SHALL force IDLE, all FIFOs empty, waiting and dep_regs zero, ptr zero, dispatched_count zero, dispatch_valid 0, dispatch_tid 0, dispatcher_busy 0, dispatcher_done 0.
REQ-028 rst mid-operation SHALL behave as REQ-027 on the next edge; rst dominates abort and start.

Structure
REQ-029 Package dispatcher_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-030 Lane FIFO SHALL be sub-module dispatch_lane_fifo (parameters WIDTH, DEPTH; outputs empty, full, count), instantiated NUM_LANES times.

Verification
REQ-031 thread_count=32, all active, unroll=2, no deps, pop every cycle -> lane l receives tids l, l+4, ..., 8 groups, dispatched_count=32, done one pulse.
REQ-032 Deps: input bit 3, pending bit 3, 8 threads -> no dispatch; wb_valid, ld_dest_reg=3, tid bitmap 0xFF -> tids 0..7 dispatched starting 2 cycles later.
REQ-033 No pops, FIFO_DEPTH=8, 64 threads, unroll=2 -> exactly 32 entries pushed, then stall; busy held, no done.
REQ-034 active_mask = 0x5 (tids 0,2), thread_count=4, unroll=0 -> lane 0 gets 0 then 2; dispatched_count=2.
REQ-035 abort during SCAN with entries queued -> next cycle all dispatch_valid=0, IDLE, busy=0, no done; new start succeeds.
REQ-036 thread_count=0 -> done asserted cycle N+3, no dispatch_valid ever.

Source files
------------

// File: rtl/dispatcher_pkg.sv
// Shared types and default constants for the multi-lane thread dispatcher.
// Contents:
//   disp_state_e  - dispatcher FSM states
//   Def*          - default parameter values for dispatcher_multilane
//   eff_lanes()   - number of lanes actually used for a given unrolling factor
package dispatcher_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } disp_state_e;

  localparam int unsigned DefNumLanes   = 4;
  localparam int unsigned DefMaxThreads = 1024;
  localparam int unsigned DefFifoDepth  = 8;
  localparam int unsigned DefNumRegs    = 66;

  // min(lanes, 2**uf): the group width and the tid-to-lane modulus.
  function automatic int unsigned eff_lanes(input logic [1:0] uf, input int unsigned lanes);
    int unsigned want;
    want = 32'd1 << uf;
    return (want < lanes) ? want : lanes;
  endfunction

endpackage

// File: rtl/dispatch_lane_fifo.sv
// Show-ahead FIFO for one dispatch lane.
// Ports:
//   clk_i, rst_i     - clock, synchronous active-high reset
//   flush_i          - empties the FIFO on the next edge, overriding push and pop
//   push_i, data_i   - write request and data (ignored when full)
//   pop_i            - consume the head entry (ignored when empty)
//   data_o           - head entry, zero while empty
//   empty_o, full_o  - occupancy flags from the registered count
//   count_o          - registered number of stored entries
module dispatch_lane_fifo #(
  parameter  int unsigned WIDTH = 10,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dispatcher_multilane.sv
// Multi-lane thread dispatcher. On start it latches a CTA description and walks
// the thread ids in groups of L_eff = min(NUM_LANES, 2**unrolling_factor). Each
// group is pushed atomically into per-lane FIFOs (tid t -> lane t mod L_eff) once
// none of its active threads waits on a pending register and every target lane
// has room. Writebacks clear per-thread waiting bits.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   start, abort                      - launch pulse (idle only), flush request
//   unrolling_factor, thread_count    - log2 group width, threads in the CTA
//   active_mask                       - per-thread enable
//   input_register_bitmap,
//   pending_reg_bitmap                - AND gives the registers threads depend on
//   wb_valid, wb_tid_bitmap,
//   ld_dest_reg                       - writeback releasing waiting threads
//   dispatch_pop/_tid/_valid          - per-lane show-ahead FIFO interface
//   dispatcher_busy, dispatcher_done,
//   dispatched_count                  - status
module dispatcher_multilane
  import dispatcher_pkg::*;
#(
  parameter  int unsigned NUM_LANES   = DefNumLanes,
  parameter  int unsigned MAX_THREADS = DefMaxThreads,
  parameter  int unsigned FIFO_DEPTH  = DefFifoDepth,
  parameter  int unsigned NUM_REGS    = DefNumRegs,
  localparam int unsigned TID_W       = $clog2(MAX_THREADS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 unrolling_factor,
  input  logic [TID_W:0]             thread_count,
  input  logic [MAX_THREADS-1:0]     active_mask,
  input  logic [NUM_REGS-1:0]        input_register_bitmap,
  input  logic [NUM_REGS-1:0]        pending_reg_bitmap,
  input  logic                       wb_valid,
  input  logic [MAX_THREADS-1:0]     wb_tid_bitmap,
  input  logic [7:0]                 ld_dest_reg,
  input  logic [NUM_LANES-1:0]       dispatch_pop,
  output logic [NUM_LANES*TID_W-1:0] dispatch_tid,
  output logic [NUM_LANES-1:0]       dispatch_valid,
  output logic                       dispatcher_busy,
  output logic                       dispatcher_done,
  output logic [TID_W:0]             dispatched_count
);

  // Two spare bits so ptr + L_eff cannot wrap past thread_count.
  localparam int unsigned PtrW   = TID_W + 2;
  localparam int unsigned LeffW  = $clog2(NUM_LANES) + 1;
  localparam int unsigned CountW = TID_W + 1;
  localparam int unsigned FCntW  = $clog2(FIFO_DEPTH) + 1;

  disp_state_e            state_q, state_d;
  logic [MAX_THREADS-1:0] mask_q, mask_d;
  logic [MAX_THREADS-1:0] waiting_q, waiting_d;
  logic [CountW-1:0]      tcount_q, tcount_d;
  logic [CountW-1:0]      count_q, count_d;
  logic [LeffW-1:0]       leff_q, leff_d;
  logic [NUM_REGS-1:0]    dep_q, dep_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;

  logic [PtrW-1:0]        lane_t   [NUM_LANES];
  logic [TID_W-1:0]       lane_tid [NUM_LANES];
  logic [FCntW-1:0]       lane_cnt [NUM_LANES];
  logic [NUM_LANES-1:0]   lane_qual, lane_push, lane_empty, lane_full, lane_idle;
  logic [CountW-1:0]      push_cnt;
  logic                   group_blocked, wb_hit;

  // Group evaluation. ptr only ever advances by L_eff from zero, so the j-th
  // member of the group always lands in lane j.
  always_comb begin
    group_blocked = 1'b0;
    lane_qual     = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      lane_t[j]    = ptr_q + PtrW'(j);
      lane_tid[j]  = lane_t[j][TID_W-1:0];
      lane_qual[j] = (LeffW'(j) < leff_q) && (lane_t[j] < PtrW'(tcount_q)) &&
                     mask_q[lane_tid[j]];
      if (lane_qual[j] && (waiting_q[lane_tid[j]] || lane_full[j])) group_blocked = 1'b1;
    end
  end

  assign lane_push = (state_q == StScan && !abort && !group_blocked) ? lane_qual : '0;

  always_comb begin
    push_cnt = '0;
    for (int j = 0; j < NUM_LANES; j++) push_cnt = push_cnt + CountW'(lane_push[j]);
  end

  // Writebacks to registers outside the bitmap or not depended on are ignored.
  always_comb begin
    wb_hit = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (dep_q[r] && (int'(ld_dest_reg) == r)) wb_hit = 1'b1;
    end
    wb_hit = wb_hit && wb_valid;
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    tcount_d  = tcount_q;
    leff_d    = leff_q;
    dep_d     = dep_q;
    waiting_d = waiting_q;
    ptr_d     = ptr_q;
    count_d   = count_q + push_cnt;

    if (wb_hit) waiting_d = waiting_q & ~wb_tid_bitmap;

    case (state_q)
      StIdle: begin
        if (start) begin
          mask_d    = active_mask;
          tcount_d  = thread_count;
          leff_d    = LeffW'(eff_lanes(unrolling_factor, NUM_LANES));
          dep_d     = input_register_bitmap & pending_reg_bitmap;
          waiting_d = |(input_register_bitmap & pending_reg_bitmap) ? active_mask : '0;
          ptr_d     = '0;
          count_d   = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        // An empty group is never blocked, so it is skipped in one cycle.
        if (!group_blocked) begin
          ptr_d = ptr_q + PtrW'(leff_q);
          if (ptr_d >= PtrW'(tcount_q)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (&lane_idle) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d   = StIdle;
      waiting_d = '0;
      ptr_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      waiting_q <= '0;
      tcount_q  <= '0;
      count_q   <= '0;
      leff_q    <= '0;
      dep_q     <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      waiting_q <= waiting_d;
      tcount_q  <= tcount_d;
      count_q   <= count_d;
      leff_q    <= leff_d;
      dep_q     <= dep_d;
      ptr_q     <= ptr_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dispatch_lane_fifo #(
      .WIDTH (TID_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (abort),
      .push_i  (lane_push[l]),
      .data_i  (lane_tid[l]),
      .pop_i   (dispatch_pop[l]),
      .data_o  (dispatch_tid[l*TID_W +: TID_W]),
      .empty_o (lane_empty[l]),
      .full_o  (lane_full[l]),
      .count_o (lane_cnt[l])
    );
    assign dispatch_valid[l] = ~lane_empty[l];
    assign lane_idle[l]      = (lane_cnt[l] == '0);
  end

  assign dispatcher_busy  = (state_q != StIdle);
  assign dispatcher_done  = (state_q == StDone);
  assign dispatched_count = count_q;

endmodule

// File: tb/tb_dispatcher_multilane.sv
module tb_dispatcher_multilane;

  localparam int unsigned NL = 4;
  localparam int unsigned MT = 1024;
  localparam int unsigned FD = 8;
  localparam int unsigned NR = 66;
  localparam int unsigned TW = 10;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [1:0]       uf;
  logic [TW:0]      tc;
  logic [MT-1:0]    am, wbb;
  logic [NR-1:0]    inb, pend;
  logic             wbv;
  logic [7:0]       ldr;
  logic [NL-1:0]    pop, dv;
  logic [NL*TW-1:0] dtid;
  logic             busy, done;
  logic [TW:0]      dcnt;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int unsigned exp_q [NL][$];

  always #5 clk = ~clk;

  dispatcher_multilane #(
    .NUM_LANES   (NL),
    .MAX_THREADS (MT),
    .FIFO_DEPTH  (FD),
    .NUM_REGS    (NR)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .abort                 (abort),
    .unrolling_factor      (uf),
    .thread_count          (tc),
    .active_mask           (am),
    .input_register_bitmap (inb),
    .pending_reg_bitmap    (pend),
    .wb_valid              (wbv),
    .wb_tid_bitmap         (wbb),
    .ld_dest_reg           (ldr),
    .dispatch_pop          (pop),
    .dispatch_tid          (dtid),
    .dispatch_valid        (dv),
    .dispatcher_busy       (busy),
    .dispatcher_done       (done),
    .dispatched_count      (dcnt)
  );

  // Monitor: every entry taken from a lane must be the next expected tid.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      for (int l = 0; l < NL; l++) begin
        if (dv[l] && pop[l]) begin
          checks++;
          if (exp_q[l].size() == 0) begin
            failures++;
            $display("FAIL lane%0d_unexpected tid=%0d expected=none", l, dtid[l*TW +: TW]);
          end else begin
            int unsigned e;
            e = exp_q[l].pop_front();
            if (32'(dtid[l*TW +: TW]) != e) begin
              failures++;
              $display("FAIL lane%0d_tid actual=%0d expected=%0d", l, dtid[l*TW +: TW], e);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_left();
    int unsigned s;
    s = 0;
    for (int l = 0; l < NL; l++) s += exp_q[l].size();
    return s;
  endfunction

  task automatic expect_run(input int unsigned n, input int unsigned lanes,
                            input logic [MT-1:0] m);
    for (int unsigned t = 0; t < n; t++) begin
      if (m[t]) exp_q[t % lanes].push_back(t);
    end
  endtask

  task automatic launch(input logic [1:0] f, input int unsigned n, input logic [MT-1:0] m,
                        input logic [NR-1:0] ib, input logic [NR-1:0] pb);
    uf    = f;
    tc    = (TW+1)'(n);
    am    = m;
    inb   = ib;
    pend  = pb;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      step();
      i++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout actual=done0 expected=done1 within %0d cycles", name, budget);
    end else begin
      step();
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [MT-1:0] all_on, m5, lo8;
    int d0;
    all_on = '1;
    m5     = '0;
    m5[2:0] = 3'b101;
    lo8    = '0;
    lo8[7:0] = 8'hFF;

    rst = 1'b1; start = 1'b0; abort = 1'b0; uf = '0; tc = '0; am = '0;
    inb = '0; pend = '0; wbv = 1'b0; wbb = '0; ldr = '0; pop = '0;
    step(); step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(dv), 32'd0);
    check("rst_tid", 32'(dtid), 32'd0);
    check("rst_count", 32'(dcnt), 32'd0);
    rst = 1'b0;
    step();

    // 32 threads, 4 lanes, pop every cycle.
    pop = '1;
    d0 = done_cnt;
    expect_run(32, 4, all_on);
    launch(2'd2, 32, all_on, '0, '0);
    check("r1_busy", 32'(busy), 32'd1);
    check("r1_valid_n1", 32'(dv), 32'd0);
    step();
    check("r1_valid_n2", 32'(dv), 32'hF);
    wait_done("r1", 60);
    check("r1_count", 32'(dcnt), 32'd32);
    check("r1_left", exp_left(), 32'd0);
    check("r1_pulses", 32'(done_cnt - d0), 32'd1);
    check("r1_idle", 32'(busy), 32'd0);

    // thread_count = 0: done three cycles after start, nothing dispatched.
    d0 = done_cnt;
    launch(2'd2, 0, all_on, '0, '0);
    check("r0_done_n1", 32'(done), 32'd0);
    step();
    check("r0_done_n2", 32'(done), 32'd0);
    step();
    check("r0_done_n3", 32'(done), 32'd1);
    check("r0_valid", 32'(dv), 32'd0);
    step();
    check("r0_done_off", 32'(done), 32'd0);
    check("r0_count", 32'(dcnt), 32'd0);
    check("r0_pulses", 32'(done_cnt - d0), 32'd1);

    // Register dependency on r3 holds 8 threads until a matching writeback.
    d0 = done_cnt;
    expect_run(8, 4, all_on);
    launch(2'd2, 8, all_on, NR'(8), NR'(8));
    step(); step();
    // A start while busy must not disturb the running CTA.
    start = 1'b1; tc = '0; inb = '0; pend = '0;
    step();
    start = 1'b0;
    wbv = 1'b1; ldr = 8'd5; wbb = lo8;
    step();
    wbv = 1'b0;
    step(); step();
    check("dep_blocked_valid", 32'(dv), 32'd0);
    check("dep_blocked_count", 32'(dcnt), 32'd0);
    check("dep_busy", 32'(busy), 32'd1);
    wbv = 1'b1; ldr = 8'd3; wbb = lo8;
    step();
    wbv = 1'b0;
    check("dep_wb_n1", 32'(dv), 32'd0);
    step();
    check("dep_wb_n2", 32'(dv), 32'hF);
    wait_done("dep", 40);
    check("dep_count", 32'(dcnt), 32'd8);
    check("dep_left", exp_left(), 32'd0);
    check("dep_pulses", 32'(done_cnt - d0), 32'd1);

    // No pops: 64 threads fill 4 lanes x 8 entries then stall.
    pop = '0;
    d0 = done_cnt;
    expect_run(64, 4, all_on);
    launch(2'd2, 64, all_on, '0, '0);
    for (int i = 0; i < 20; i++) step();
    check("full_count", 32'(dcnt), 32'd32);
    check("full_busy", 32'(busy), 32'd1);
    check("full_valid", 32'(dv), 32'hF);
    check("full_head1", 32'(dtid[1*TW +: TW]), 32'd1);
    check("full_no_done", 32'(done_cnt - d0), 32'd0);
    pop = '1;
    wait_done("full", 120);
    check("full_final", 32'(dcnt), 32'd64);
    check("full_left", exp_left(), 32'd0);

    // Abort with entries queued.
    pop = '0;
    d0 = done_cnt;
    launch(2'd2, 32, all_on, '0, '0);
    step(); step();
    check("ab_pre_valid", 32'(dv), 32'hF);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_valid", 32'(dv), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    step(); step();
    check("ab_no_pulse", 32'(done_cnt - d0), 32'd0);
    check("ab_still_idle", 32'(busy), 32'd0);

    // Sparse mask, single lane: lane 0 gets 0 then 2.
    pop = '1;
    d0 = done_cnt;
    expect_run(4, 1, m5);
    launch(2'd0, 4, m5, '0, '0);
    wait_done("sparse", 30);
    check("sparse_count", 32'(dcnt), 32'd2);
    check("sparse_left", exp_left(), 32'd0);
    check("sparse_pulses", 32'(done_cnt - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
